// File: rtl/pkg_amba3.sv
// Shared AXI3 encodings and the FSM state types for the SRAM slave.
package pkg_amba3;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
   typedef enum logic {R_IDLE, R_DATA} rstate_e;

   // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_ok(input logic [3:0] len);
      return len inside {4'd1, 4'd3, 4'd7, 4'd15};
   endfunction

endpackage

// File: rtl/amba3_axi_if.sv
// AXI3 five-channel bundle with master and slave views.
interface amba3_axi_if #(
   parameter int AXID_SIZE = 4,
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 128
);
   logic [AXID_SIZE-1:0]   awid;
   logic [ADDR_SIZE-1:0]   awaddr;
   logic [3:0]             awlen;
   logic [2:0]             awsize;
   logic [1:0]             awburst;
   logic                   awvalid;
   logic                   awready;
   logic [AXID_SIZE-1:0]   wid;
   logic [DATA_SIZE-1:0]   wdata;
   logic [DATA_SIZE/8-1:0] wstrb;
   logic                   wlast;
   logic                   wvalid;
   logic                   wready;
   logic [AXID_SIZE-1:0]   bid;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [AXID_SIZE-1:0]   arid;
   logic [ADDR_SIZE-1:0]   araddr;
   logic [3:0]             arlen;
   logic [2:0]             arsize;
   logic [1:0]             arburst;
   logic                   arvalid;
   logic                   arready;
   logic [AXID_SIZE-1:0]   rid;
   logic [DATA_SIZE-1:0]   rdata;
   logic [1:0]             rresp;
   logic                   rlast;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wid, wdata, wstrb, wlast, wvalid, input wready,
      input bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input rid, rdata, rresp, rlast, rvalid, output rready
   );

   modport slave (
      input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input wid, wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

// File: rtl/amba3_axi_addr_gen.sv
// Next-beat address and burst legality for one AXI burst context.
module amba3_axi_addr_gen
   import pkg_amba3::*;
#(
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 128
) (
   input  logic [ADDR_SIZE-1:0] addr,
   input  logic [3:0]           len,
   input  logic [2:0]           size,
   input  logic [1:0]           burst,
   output logic [ADDR_SIZE-1:0] next_addr,
   output logic                 illegal
);
   localparam int STRB_W = DATA_SIZE / 8;

   logic [ADDR_SIZE-1:0] step;
   logic [ADDR_SIZE-1:0] incr;
   logic [ADDR_SIZE-1:0] wrap_mask;

   // Step by the beat size; WRAP keeps the upper bits of the aligned block.
   always_comb begin
      step      = ADDR_SIZE'(1) << size;
      incr      = addr + step;
      wrap_mask = ((ADDR_SIZE'(len) + ADDR_SIZE'(1)) << size) - ADDR_SIZE'(1);
      illegal   = (burst == BURST_RSVD) || (step > ADDR_SIZE'(STRB_W)) ||
                  ((burst == BURST_WRAP) && !wrap_len_ok(len));
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
         default:     next_addr = incr;
      endcase
   end
endmodule

// File: rtl/amba3_axi_sram_slave.sv
// AXI3 slave in front of a single-port-per-path SRAM array.
// Independent write and read FSMs, one burst in flight on each.
module amba3_axi_sram_slave
   import pkg_amba3::*;
#(
   parameter int AXID_SIZE = 4,
   parameter int ADDR_SIZE = 32,
   parameter int DATA_SIZE = 128,
   parameter int MEM_WORDS = 1024
) (
   input  logic        aclk,
   input  logic        areset_n,
   amba3_axi_if.slave  axi
);
   localparam int STRB_W = DATA_SIZE / 8;
   localparam int OFF_W  = $clog2(STRB_W);
   localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

   logic [DATA_SIZE-1:0] mem [MEM_WORDS];

   function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
      return (a >> OFF_W) < ADDR_SIZE'(MEM_WORDS);
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [ADDR_SIZE-1:0] a);
      return IDX_W'(a >> OFF_W);
   endfunction

   // ---------------- write path ----------------
   wstate_e              wst_q, wst_d;
   logic [AXID_SIZE-1:0] awid_q, awid_d, bid_q, bid_d;
   logic [ADDR_SIZE-1:0] waddr_q, waddr_d, w_next;
   logic [3:0]           awlen_q, awlen_d, wbeat_q, wbeat_d;
   logic [2:0]           awsize_q, awsize_d;
   logic [1:0]           awburst_q, awburst_d;
   logic                 werr_q, werr_d;
   logic                 awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   resp_e                bresp_q, bresp_d;
   logic                 w_illegal, w_last_beat, w_beat_err, mem_we;

   amba3_axi_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) u_wgen (
      .addr(waddr_q), .len(awlen_q), .size(awsize_q), .burst(awburst_q),
      .next_addr(w_next), .illegal(w_illegal)
   );

   // Write FSM: capture AW, accept beats, hold B until taken. Errors accumulate per burst.
   always_comb begin
      wst_d     = wst_q;
      awid_d    = awid_q;
      waddr_d   = waddr_q;
      awlen_d   = awlen_q;
      awsize_d  = awsize_q;
      awburst_d = awburst_q;
      wbeat_d   = wbeat_q;
      werr_d    = werr_q;
      bresp_d   = bresp_q;
      bid_d     = bid_q;
      mem_we    = 1'b0;
      w_last_beat = (wbeat_q == awlen_q);
      w_beat_err  = w_illegal || !in_range(waddr_q) ||
                    (axi.wlast != w_last_beat) || (axi.wid != awid_q);
      case (wst_q)
         W_IDLE: if (axi.awvalid && awready_q) begin
            awid_d    = axi.awid;
            waddr_d   = axi.awaddr;
            awlen_d   = axi.awlen;
            awsize_d  = axi.awsize;
            awburst_d = axi.awburst;
            wbeat_d   = 4'd0;
            werr_d    = 1'b0;
            wst_d     = W_DATA;
         end
         W_DATA: if (axi.wvalid && wready_q) begin
            mem_we  = !w_illegal && in_range(waddr_q);
            waddr_d = w_next;
            wbeat_d = wbeat_q + 4'd1;
            werr_d  = werr_q || w_beat_err;
            if (w_last_beat) begin
               bresp_d = (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
               bid_d   = awid_q;
               wst_d   = W_RESP;
            end
         end
         W_RESP: if (bvalid_q && axi.bready) wst_d = W_IDLE;
         default: wst_d = W_IDLE;
      endcase
      awready_d = (wst_d == W_IDLE);
      wready_d  = (wst_d == W_DATA);
      bvalid_d  = (wst_d == W_RESP);
   end

   // Write-path state; ready flags are registered so they rise one edge after reset release.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         wst_q     <= W_IDLE;
         awid_q    <= '0;
         waddr_q   <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         awburst_q <= '0;
         wbeat_q   <= '0;
         werr_q    <= 1'b0;
         bresp_q   <= RESP_OKAY;
         bid_q     <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         wst_q     <= wst_d;
         awid_q    <= awid_d;
         waddr_q   <= waddr_d;
         awlen_q   <= awlen_d;
         awsize_q  <= awsize_d;
         awburst_q <= awburst_d;
         wbeat_q   <= wbeat_d;
         werr_q    <= werr_d;
         bresp_q   <= bresp_d;
         bid_q     <= bid_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
      end
   end

   // Byte-enabled array write; contents survive reset.
   always_ff @(posedge aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STRB_W; b++)
            if (axi.wstrb[b]) mem[idx(waddr_q)][b*8 +: 8] <= axi.wdata[b*8 +: 8];
      end
   end

   assign axi.awready = awready_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = bresp_q;
   assign axi.bid     = bid_q;

   // ---------------- read path ----------------
   rstate_e              rst_q, rst_d;
   logic [AXID_SIZE-1:0] rid_q, rid_d;
   logic [ADDR_SIZE-1:0] raddr_q, raddr_d, r_next, rg_addr, rd_addr;
   logic [3:0]           arlen_q, arlen_d, rbeat_q, rbeat_d, rg_len;
   logic [2:0]           arsize_q, arsize_d, rg_size;
   logic [1:0]           arburst_q, arburst_d, rg_burst;
   logic                 arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [DATA_SIZE-1:0] rdata_q, rdata_d, rd_word;
   resp_e                rresp_q, rresp_d, rd_resp;
   logic                 r_idle, r_illegal, rd_ok;

   // While idle the generator looks at the AR channel so the first beat can be judged at handshake.
   assign r_idle   = (rst_q == R_IDLE);
   assign rg_addr  = r_idle ? axi.araddr  : raddr_q;
   assign rg_len   = r_idle ? axi.arlen   : arlen_q;
   assign rg_size  = r_idle ? axi.arsize  : arsize_q;
   assign rg_burst = r_idle ? axi.arburst : arburst_q;

   amba3_axi_addr_gen #(.ADDR_SIZE(ADDR_SIZE), .DATA_SIZE(DATA_SIZE)) u_rgen (
      .addr(rg_addr), .len(rg_len), .size(rg_size), .burst(rg_burst),
      .next_addr(r_next), .illegal(r_illegal)
   );

   // Fetch for the beat about to be loaded; array read precedes a same-edge write.
   always_comb begin
      rd_addr = r_idle ? axi.araddr : r_next;
      rd_ok   = !r_illegal && in_range(rd_addr);
      rd_word = rd_ok ? mem[idx(rd_addr)] : '0;
      rd_resp = rd_ok ? RESP_OKAY : RESP_SLVERR;
   end

   // Read FSM: load beat 0 on AR handshake, load the next beat on each non-final R handshake.
   always_comb begin
      rst_d     = rst_q;
      rid_d     = rid_q;
      raddr_d   = raddr_q;
      arlen_d   = arlen_q;
      arsize_d  = arsize_q;
      arburst_d = arburst_q;
      rbeat_d   = rbeat_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      case (rst_q)
         R_IDLE: if (axi.arvalid && arready_q) begin
            rid_d     = axi.arid;
            raddr_d   = axi.araddr;
            arlen_d   = axi.arlen;
            arsize_d  = axi.arsize;
            arburst_d = axi.arburst;
            rbeat_d   = 4'd0;
            rdata_d   = rd_word;
            rresp_d   = rd_resp;
            rlast_d   = (axi.arlen == 4'd0);
            rst_d     = R_DATA;
         end
         R_DATA: if (rvalid_q && axi.rready) begin
            if (rlast_q) begin
               rlast_d = 1'b0;
               rst_d   = R_IDLE;
            end else begin
               raddr_d = r_next;
               rbeat_d = rbeat_q + 4'd1;
               rdata_d = rd_word;
               rresp_d = rd_resp;
               rlast_d = ((rbeat_q + 4'd1) == arlen_q);
            end
         end
         default: rst_d = R_IDLE;
      endcase
      arready_d = (rst_d == R_IDLE);
      rvalid_d  = (rst_d == R_DATA);
   end

   // Read-path state and registered R channel outputs.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         rst_q     <= R_IDLE;
         rid_q     <= '0;
         raddr_q   <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
         rbeat_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         rlast_q   <= 1'b0;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
      end else begin
         rst_q     <= rst_d;
         rid_q     <= rid_d;
         raddr_q   <= raddr_d;
         arlen_q   <= arlen_d;
         arsize_q  <= arsize_d;
         arburst_q <= arburst_d;
         rbeat_q   <= rbeat_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
      end
   end

   assign axi.arready = arready_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rid     = rid_q;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;
   assign axi.rlast   = rlast_q;

endmodule

// File: tb/tb_amba3_axi_sram_slave.sv
// Directed bench for the AXI3 SRAM slave: vector table plus stall and reset sequences.
module tb_amba3_axi_sram_slave;
   localparam int TMO = 50;
   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] SLV = 2'b10;
   localparam logic [1:0] FX = 2'b00, IN = 2'b01, WR = 2'b10, RS = 2'b11;

   typedef struct {
      bit               wr;
      logic [3:0]       id;
      logic [3:0]       wid;
      logic [31:0]      addr;
      logic [3:0]       len;
      logic [2:0]       size;
      logic [1:0]       burst;
      logic [15:0]      strb;
      int               wlb;
      logic [3:0][127:0] data;
      logic [3:0][1:0]  resp;
   } vec_t;

   logic aclk = 1'b0;
   logic areset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   vec_t vt [16];

   always #5 aclk = ~aclk;

   amba3_axi_if #(.AXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(128)) axi ();

   amba3_axi_sram_slave #(.AXID_SIZE(4), .ADDR_SIZE(32), .DATA_SIZE(128), .MEM_WORDS(1024)) dut (
      .aclk(aclk), .areset_n(areset_n), .axi(axi)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no handshake expected one within %0d cycles", name, TMO);
   endtask

   function automatic vec_t mk(bit wr, logic [3:0] id, logic [3:0] wid, logic [31:0] addr,
                               logic [3:0] len, logic [2:0] size, logic [1:0] burst,
                               logic [15:0] strb, int wlb,
                               logic [127:0] d0, logic [127:0] d1, logic [127:0] d2, logic [127:0] d3,
                               logic [1:0] r0, logic [1:0] r1, logic [1:0] r2, logic [1:0] r3);
      vec_t v;
      v.wr = wr; v.id = id; v.wid = wid; v.addr = addr; v.len = len; v.size = size;
      v.burst = burst; v.strb = strb; v.wlb = wlb;
      v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
      v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2; v.resp[3] = r3;
      return v;
   endfunction

   task automatic do_write(input int k, input vec_t v);
      int n;
      axi.awid = v.id; axi.awaddr = v.addr; axi.awlen = v.len;
      axi.awsize = v.size; axi.awburst = v.burst; axi.awvalid = 1'b1;
      n = 0;
      while (axi.awready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) tmo($sformatf("v%0d aw", k));
      @(negedge aclk);
      axi.awvalid = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) begin
         axi.wid = v.wid; axi.wdata = v.data[b]; axi.wstrb = v.strb;
         axi.wlast = (b == v.wlb); axi.wvalid = 1'b1;
         n = 0;
         while (axi.wready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
         if (n >= TMO) tmo($sformatf("v%0d w%0d", k, b));
         @(negedge aclk);
      end
      axi.wvalid = 1'b0; axi.wlast = 1'b0; axi.bready = 1'b1;
      n = 0;
      while (axi.bvalid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) tmo($sformatf("v%0d b", k));
      chk($sformatf("v%0d bresp", k), 128'(axi.bresp), 128'(v.resp[0]));
      chk($sformatf("v%0d bid", k), 128'(axi.bid), 128'(v.id));
      @(negedge aclk);
      axi.bready = 1'b0;
   endtask

   task automatic send_ar(input int k, input vec_t v);
      int n;
      axi.arid = v.id; axi.araddr = v.addr; axi.arlen = v.len;
      axi.arsize = v.size; axi.arburst = v.burst; axi.arvalid = 1'b1;
      n = 0;
      while (axi.arready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) tmo($sformatf("v%0d ar", k));
      @(negedge aclk);
      axi.arvalid = 1'b0;
      chk($sformatf("v%0d rvalid latency", k), 128'(axi.rvalid), 128'(1));
   endtask

   task automatic read_beat(input int k, input vec_t v, input int b);
      int n;
      n = 0;
      while (axi.rvalid !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) tmo($sformatf("v%0d r%0d", k, b));
      chk($sformatf("v%0d rdata%0d", k, b), axi.rdata, v.data[b]);
      chk($sformatf("v%0d rresp%0d", k, b), 128'(axi.rresp), 128'(v.resp[b]));
      chk($sformatf("v%0d rlast%0d", k, b), 128'(axi.rlast), 128'(b == int'(v.len)));
      chk($sformatf("v%0d rid%0d", k, b), 128'(axi.rid), 128'(v.id));
      @(negedge aclk);
   endtask

   task automatic do_read(input int k, input vec_t v);
      send_ar(k, v);
      axi.rready = 1'b1;
      for (int b = 0; b <= int'(v.len); b++) read_beat(k, v, b);
      axi.rready = 1'b0;
   endtask

   initial begin
      vec_t v;
      logic [127:0] hold_d;
      int n;
      axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0; axi.awvalid = 1'b0;
      axi.wid = '0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b0;
      axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0; axi.arvalid = 1'b0;
      axi.rready = 1'b0;

      //        wr  id    wid   addr          len   sz    burst strb      wlb data                                                        resp
      vt[0]  = mk(1, 4'h5, 4'h5, 32'h100,      4'd3, 3'd4, IN, 16'hFFFF, 3, 128'hA0, 128'hA1, 128'hA2, 128'hA3, OK, OK, OK, OK);
      vt[1]  = mk(0, 4'h6, 4'h0, 32'h100,      4'd3, 3'd4, IN, 16'h0,    0, 128'hA0, 128'hA1, 128'hA2, 128'hA3, OK, OK, OK, OK);
      vt[2]  = mk(0, 4'h7, 4'h0, 32'h130,      4'd3, 3'd4, WR, 16'h0,    0, 128'hA3, 128'hA0, 128'hA1, 128'hA2, OK, OK, OK, OK);
      vt[3]  = mk(1, 4'h1, 4'h1, 32'h200,      4'd0, 3'd4, IN, 16'hFFFF, 0, {128{1'b1}}, 0, 0, 0, OK, OK, OK, OK);
      vt[4]  = mk(1, 4'h2, 4'h2, 32'h200,      4'd0, 3'd4, IN, 16'h000F, 0,
                  128'h11223344_55667788_99AABBCC_DDEEFF00, 0, 0, 0, OK, OK, OK, OK);
      vt[5]  = mk(0, 4'h3, 4'h0, 32'h200,      4'd0, 3'd4, IN, 16'h0,    0,
                  128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_DDEEFF00, 0, 0, 0, OK, OK, OK, OK);
      vt[6]  = mk(1, 4'h4, 4'h4, 32'h300,      4'd1, 3'd4, IN, 16'hFFFF, 0, 128'h1, 128'h2, 0, 0, SLV, OK, OK, OK);
      vt[7]  = mk(0, 4'h8, 4'h0, 32'h110,      4'd2, 3'd4, FX, 16'h0,    0, 128'hA1, 128'hA1, 128'hA1, 0, OK, OK, OK, OK);
      vt[8]  = mk(0, 4'h9, 4'h0, 32'h4000,     4'd0, 3'd4, IN, 16'h0,    0, 0, 0, 0, 0, SLV, OK, OK, OK);
      vt[9]  = mk(0, 4'hA, 4'h0, 32'h100,      4'd1, 3'd4, RS, 16'h0,    0, 0, 0, 0, 0, SLV, SLV, OK, OK);
      vt[10] = mk(1, 4'hB, 4'hB, 32'h100,      4'd2, 3'd4, WR, 16'hFFFF, 2, 128'hBAD0, 128'hBAD1, 128'hBAD2, 0, SLV, OK, OK, OK);
      vt[11] = mk(0, 4'hC, 4'h0, 32'h100,      4'd0, 3'd4, IN, 16'h0,    0, 128'hA0, 0, 0, 0, OK, OK, OK, OK);
      vt[12] = mk(0, 4'hD, 4'h0, 32'h100,      4'd0, 3'd5, IN, 16'h0,    0, 0, 0, 0, 0, SLV, OK, OK, OK);
      vt[13] = mk(1, 4'hE, 4'hF, 32'h400,      4'd0, 3'd4, IN, 16'hFFFF, 0, 128'h77, 0, 0, 0, SLV, OK, OK, OK);
      vt[14] = mk(1, 4'h1, 4'h1, 32'hFFFFFFF0, 4'd1, 3'd4, IN, 16'hFFFF, 1, 128'hC0, 128'hC1, 0, 0, SLV, OK, OK, OK);
      vt[15] = mk(0, 4'h2, 4'h0, 32'hFFFFFFF0, 4'd1, 3'd4, IN, 16'h0,    0, 0, 128'hC1, 0, 0, SLV, OK, OK, OK);

      // reset state
      repeat (3) @(negedge aclk);
      chk("rst awready", 128'(axi.awready), 128'(0));
      chk("rst wready",  128'(axi.wready),  128'(0));
      chk("rst bvalid",  128'(axi.bvalid),  128'(0));
      chk("rst arready", 128'(axi.arready), 128'(0));
      chk("rst rvalid",  128'(axi.rvalid),  128'(0));
      chk("rst rlast",   128'(axi.rlast),   128'(0));
      chk("rst bresp",   128'(axi.bresp),   128'(0));
      chk("rst rresp",   128'(axi.rresp),   128'(0));
      chk("rst bid",     128'(axi.bid),     128'(0));
      chk("rst rid",     128'(axi.rid),     128'(0));
      chk("rst rdata",   axi.rdata,         128'(0));
      areset_n = 1'b1;
      #1;
      chk("release awready pre-edge", 128'(axi.awready), 128'(0));
      @(negedge aclk);
      chk("release awready", 128'(axi.awready), 128'(1));
      chk("release arready", 128'(axi.arready), 128'(1));

      for (int k = 0; k < 16; k++) begin
         if (vt[k].wr) do_write(k, vt[k]);
         else          do_read(k, vt[k]);
      end

      // rready held low for 5 cycles with beat 1 on the bus
      v = vt[1];
      send_ar(100, v);
      axi.rready = 1'b1;
      read_beat(100, v, 0);
      axi.rready = 1'b0;
      hold_d = v.data[1];
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d rvalid", c), 128'(axi.rvalid), 128'(1));
         chk($sformatf("stall%0d rdata", c), axi.rdata, hold_d);
         chk($sformatf("stall%0d rlast", c), 128'(axi.rlast), 128'(0));
         @(negedge aclk);
      end
      axi.rready = 1'b1;
      for (int b = 1; b <= 3; b++) read_beat(100, v, b);
      axi.rready = 1'b0;

      // reset pulsed after AW handshake of a write burst
      axi.awid = 4'h9; axi.awaddr = 32'h100; axi.awlen = 4'd3; axi.awsize = 3'd4;
      axi.awburst = IN; axi.awvalid = 1'b1;
      n = 0;
      while (axi.awready !== 1'b1 && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) tmo("mid-rst aw");
      @(negedge aclk);
      axi.awvalid = 1'b0;
      chk("mid-rst wready before", 128'(axi.wready), 128'(1));
      areset_n = 1'b0;
      #1;
      chk("mid-rst wready", 128'(axi.wready), 128'(0));
      chk("mid-rst bvalid", 128'(axi.bvalid), 128'(0));
      repeat (2) @(negedge aclk);
      areset_n = 1'b1;
      @(negedge aclk);
      chk("mid-rst awready after", 128'(axi.awready), 128'(1));
      chk("mid-rst bvalid after", 128'(axi.bvalid), 128'(0));
      chk("mid-rst wready after", 128'(axi.wready), 128'(0));
      do_read(200, vt[1]);
      do_read(201, vt[5]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected finish before 200000 time units");
      $fatal(1);
   end
endmodule

// File: doc/amba3_axi_sram_slave.md
AMBA3_AXI_SRAM_SLAVE -- requirements
Module: amba3_axi_sram_slave

Interface
REQ-001 Parameter AXID_SIZE, default 4, ID width of all channels.
REQ-002 Parameter ADDR_SIZE, default 32, address width.
REQ-003 Parameter DATA_SIZE, default 128, data width in bits (power of two, >= 32).
REQ-004 Parameter MEM_WORDS, default 1024, memory depth in DATA_SIZE-bit words.
REQ-005 aclk  in  1  single clock; all logic on rising edge.
REQ-006 areset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 AW: awid/awaddr/awlen[3:0]/awsize[2:0]/awburst[1:0]/awvalid in; awready out.
REQ-008 W: wid/wdata/wstrb[DATA_SIZE/8]/wlast/wvalid in; wready out.
REQ-009 B: bid/bresp[1:0]/bvalid out; bready in.
REQ-010 AR: arid/araddr/arlen[3:0]/arsize[2:0]/arburst[1:0]/arvalid in; arready out.
REQ-011 R: rid/rdata/rresp[1:0]/rlast/rvalid out; rready in.
REQ-012 Ports SHALL match amba3_axi_if slave-side signal names so the block binds to the existing interface and consumes traffic from amba3_axi_master_t.

Function
REQ-013 Write and read paths SHALL be independent FSMs; one outstanding burst per path.
REQ-014 Write FSM: W_IDLE (awready=1) -> AW handshake captures id/addr/len/size/burst -> W_DATA (wready=1).
REQ-015 W_DATA: each W handshake writes enabled bytes (wstrb) of current word, advances address, increments beat counter.
REQ-016 W_DATA -> W_RESP on the handshake of beat awlen; bvalid=1, bid=captured awid.
REQ-017 W_RESP -> W_IDLE on bvalid&&bready; bvalid, bid, bresp held stable until then.
REQ-018 bresp SHALL be SLVERR(2'b10) if any beat out of range, wlast mismatched the beat count, wid != awid, or the burst is illegal; else OKAY(2'b00).
REQ-019 Read FSM: R_IDLE (arready=1) -> AR handshake -> R_DATA; rvalid SHALL rise the cycle after the AR handshake.
REQ-020 R_DATA: rid=captured arid, rlast=1 only on beat arlen; rdata/rresp/rlast held stable while rvalid&&!rready.
REQ-021 R_DATA -> R_IDLE on handshake of beat arlen; next beat presented the cycle after each non-final handshake.
REQ-022 Address gen: FIXED keeps address; INCR adds 2^size; WRAP adds 2^size, wrapping within aligned block of (len+1)*2^size bytes.
REQ-023 Illegal burst: burst==2'b11, 2^size > DATA_SIZE/8, or WRAP with len not in {1,3,7,15}; all beats SLVERR, no writes, rdata=0.
REQ-024 Word index = address >> log2(DATA_SIZE/8); index >= MEM_WORDS SHALL give SLVERR for that beat, suppress write, rdata=0.
REQ-025 Read and write to same word in same cycle: read returns pre-write data.
REQ-026 ADDR_SIZE arithmetic SHALL wrap modulo 2^ADDR_SIZE without error.

Reset
REQ-027 While areset_n=0: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp, bid, rid, rdata = 0; both FSMs in IDLE.
REQ-028 awready and arready SHALL assert on the first rising edge after reset release.
REQ-029 Reset mid-burst SHALL abandon the burst with no response; memory contents are not reset.

Structure
REQ-030 Burst type (FIXED/INCR/WRAP) and response (OKAY/EXOKAY/SLVERR/DECERR) enums SHALL live in pkg_amba3.
REQ-031 Next-address computation SHALL be one sub-module amba3_axi_addr_gen, instantiated once per path.

Verification
REQ-032 After reset: INCR write addr 0x100, len 3, size 4, strb all-ones, data 0xA0..0xA3 -> bresp OKAY, bid=awid; INCR read of same -> 4 beats 0xA0..0xA3, rlast on beat 3.
REQ-033 WRAP read addr 0x130, len 3, size 4 -> beat addresses 0x130, 0x100, 0x110, 0x120.
REQ-034 Write with wstrb=16'h000F over 0xFF..FF word -> read returns only low 4 bytes updated.
REQ-035 rready held low 5 cycles mid-burst -> rdata/rlast unchanged; awlen=1 with wlast on beat 0 -> bresp SLVERR.
REQ-036 Read at word index MEM_WORDS -> rresp SLVERR, rdata 0; areset_n pulsed mid-write burst -> bvalid=0, awready=1 after release, prior memory data intact.
